// File: rtl/md_pipe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : md_pipe_sequencer
// Purpose  : Sequences the multi-cycle multiply/divide unit of the 5-stage
//            MIPS pipeline. It counts the mult/div latency and pulses the
//            HI/LO write at completion. It also merges its own HI/LO hazard
//            with the external Tuse/Tnew hazard request into one
//            stallF/stallD/flushE set.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MULT_CYCLES      busy cycles for mult/multu (1..15)
//   DIV_CYCLES       busy cycles for div/divu   (1..15)
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-low reset
//   startE           mult/div instruction is in E this cycle
//   opE[1:0]         00 mult, 01 multu, 10 div, 11 divu (valid with startE)
//   md_useD          instruction in D touches the MDU or HI/LO
//   hazard_in        external data-hazard stall request
//   busy             MDU operation in flight (registered)
//   stallF           hold PC
//   stallD           hold the F/D register
//   flushE           insert a bubble into D/E
//   hilo_we          one-cycle HI/LO write strobe at completion (registered)
//   op_done[1:0]     opcode of the completing operation, valid with hilo_we
//   start_err        sticky flag: startE seen while busy
//   md_stall_cycles  (MD_PERF_CNT_EN only) count of MDU-caused stall cycles
// Configuration macro:
//   MD_PERF_CNT_EN   adds the md_stall_cycles performance counter
// ============================================================================
module md_pipe_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic        md_useD,
    input  logic        hazard_in,
    output logic        busy,
    output logic        stallF,
    output logic        stallD,
    output logic        flushE,
    output logic        hilo_we,
    output logic [1:0]  op_done,
`ifdef MD_PERF_CNT_EN
    output logic        start_err,
    output logic [31:0] md_stall_cycles
`else
    output logic        start_err
`endif
);

    // ------------------------------------------------------------------------
    // Constants: the counter is loaded with N-1 so that the BUSY state lasts
    // exactly N cycles (N, N-1 ... down to the cnt==0 cycle).
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_mult_load = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] c_div_load  = 4'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [1:0]  r_op;
    logic [1:0]  w_op_nxt;
    logic        r_hilo_we;
    logic        w_hilo_we_nxt;
    logic [1:0]  r_op_done;
    logic [1:0]  w_op_done_nxt;
    logic        r_start_err;
    logic        w_start_err_nxt;
    logic        w_md_hazard;
    logic        w_stall;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_op        <= 2'b00;
            r_hilo_we   <= 1'b0;
            r_op_done   <= 2'b00;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op        <= w_op_nxt;
            r_hilo_we   <= w_hilo_we_nxt;
            r_op_done   <= w_op_done_nxt;
            r_start_err <= w_start_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_op_nxt        = r_op;
        w_hilo_we_nxt   = 1'b0;
        w_op_done_nxt   = 2'b00;
        w_start_err_nxt = r_start_err;

        case (r_state)
            IDLE: begin
                if (startE) begin
                    w_op_nxt    = opE;
                    w_cnt_nxt   = opE[1] ? c_div_load : c_mult_load;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // A start while busy (including the completing cycle) is
                // dropped; the unit cannot queue a second operation.
                if (startE) begin
                    w_start_err_nxt = 1'b1;
                end
                if (r_cnt == 4'd0) begin
                    w_state_nxt   = IDLE;
                    w_hilo_we_nxt = 1'b1;
                    w_op_done_nxt = r_op;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Stall merge. The hilo_we term keeps a mfhi/mflo in D held for the
    // write cycle, so HI/LO is written before it is read.
    // ------------------------------------------------------------------------
    assign w_md_hazard = md_useD & (startE | busy | r_hilo_we);
    assign w_stall     = w_md_hazard | hazard_in;

    assign busy      = (r_state == BUSY);
    assign stallF    = w_stall;
    assign stallD    = w_stall;
    assign flushE    = w_stall;
    assign hilo_we   = r_hilo_we;
    assign op_done   = r_op_done;
    assign start_err = r_start_err;

`ifdef MD_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counter: only MDU-caused stalls count, wraps naturally.
    // ------------------------------------------------------------------------
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_md_hazard) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign md_stall_cycles = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/md_pipe_sequencer.md
Name: md_pipe_sequencer

Overview:
- Sequences the multi-cycle multiply/divide unit in the 5-stage MIPS pipeline and generates the F/D stall and E flush that freeze the F/D pipeline register while HI/LO are pending.
- Counts mult/div latency, pulses the HI/LO write at completion, and merges an external hazard request into one stall/flush set.
- Sits beside the hazard unit in the E stage; drives stallD of the D-stage register and the PC enable.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after issue (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu after issue (legal range 1..15)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset: one clock; reset is synchronous and active-low (asserted when 0, sampled on posedge clk)
- startE  input  1  mult/div instruction is in E this cycle
- opE  input  2  00 mult, 01 multu, 10 div, 11 divu; valid when startE=1
- md_useD  input  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
- hazard_in  input  1  external data-hazard stall request from the Tuse/Tnew unit
- busy  output  1  MDU operation in flight (registered)
- stallF  output  1  hold PC
- stallD  output  1  hold the F/D register
- flushE  output  1  insert a bubble into D/E
- hilo_we  output  1  one-cycle HI/LO write strobe at completion (registered)
- op_done  output  2  opcode of the completing operation, valid with hilo_we
- start_err  output  1  sticky: startE seen while busy

Behaviour:
- States: IDLE, BUSY. Down-counter cnt is 4 bits; op_reg is 2 bits.
- Reset (reset==0 at posedge): state=IDLE, cnt=0, op_reg=0, busy=0, hilo_we=0, op_done=0, start_err=0. An in-flight operation is aborted with no hilo_we pulse. Reset has priority over all other inputs.
- IDLE, startE=1: op_reg<=opE, cnt<=(opE[1] ? DIV_CYCLES : MULT_CYCLES)-1, state<=BUSY, busy<=1 from the next cycle.
- BUSY, cnt!=0: cnt<=cnt-1.
- BUSY, cnt==0: state<=IDLE, busy<=0, hilo_we<=1 for exactly one cycle, op_done<=op_reg.
- Timing: busy is high for exactly N cycles, where N is MULT_CYCLES or DIV_CYCLES. hilo_we is high in the cycle immediately after busy falls.
- hilo_we and op_done return to 0 in the cycle after the pulse unless a new completion occurs.
- startE while BUSY: the operation is ignored (no restart, cnt unaffected) and start_err<=1. start_err is cleared only by reset.
- startE in the same cycle that BUSY completes (cnt==0): counts as while BUSY and is ignored with start_err set. The completion proceeds normally.
- Stall logic (combinational):
  - md_hazard = md_useD & (startE | busy | hilo_we)
  - stallF = stallD = flushE = md_hazard | hazard_in
- Because of the hilo_we term, a mfhi/mflo in D is held one extra cycle so HI/LO is written before it is read.
- No combinational path from any output back to startE.

Optional Feature:
- Macro: MD_PERF_CNT_EN.
- Defined: adds output md_stall_cycles [31:0].
  - Reset value 0.
  - Increments by 1 each clock where md_hazard=1 and reset is deasserted.
  - Wraps from 32'hFFFFFFFF to 0.
  - hazard_in-only stalls are not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset held low 2 cycles mid-div (cnt=6) -> busy=0, hilo_we=0 on every following cycle, start_err=0, state IDLE.
- startE=1 opE=00 at cycle 0 -> busy=1 on cycles 1..5, hilo_we=1 only on cycle 6 with op_done=00.
- startE=1 opE=11 at cycle 0, md_useD=1 from cycle 1 -> stallD=stallF=flushE=1 on cycles 1..11, stallD=0 on cycle 12; hilo_we=1 on cycle 11 with op_done=11.
- Div issued at cycle 0, second startE at cycle 4 -> start_err=1 from cycle 5 and stays 1; completion still occurs on cycle 11 and only once.
- busy=0, md_useD=0, hazard_in=1 -> stallF=stallD=flushE=1 in the same cycle; hazard_in=0, md_useD=1, busy=0, startE=0, hilo_we=0 -> all stalls 0.
- With MD_PERF_CNT_EN: mult issued, md_useD=1 for cycles 1..6 -> md_stall_cycles=6 after cycle 6; preload near 32'hFFFFFFFF by force -> wraps to 0.
